bfp_index_scheduler: RTL and testbench

Block-floating-point exponent scheduler for the FFT pipeline. It watches a butterfly-stage output stream and measures the per-frame headroom (minimum redundant sign bits) separately for lanes 0-7 and lanes 8-15. It queues one index pair per frame and releases each pair to the downstream normalisation shifter when that stage signals the start of the matching frame. This replaces fixed-depth index delay lines with a frame-synchronous handshake, so pipeline latency changes no longer require retuning delays.

---
 rtl/fft_bfp_pkg.sv | 34 +++
 rtl/bfp_index_scheduler_if.sv | 30 +++
 rtl/bfp_index_fifo.sv | 59 +++++
 rtl/bfp_index_scheduler.sv | 125 ++++++++++++
 tb/tb_bfp_index_scheduler.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_bfp_pkg.sv
// rtl/fft_bfp_pkg.sv - shared types and headroom helpers for the BFP index scheduler
package fft_bfp_pkg;

    localparam int IDX_W    = 5;
    localparam int MAX_DATA = 32;

    typedef struct packed {
        logic [IDX_W-1:0] l;
        logic [IDX_W-1:0] h;
    } idx_pair_t;

    // Redundant sign bits of a data_w-bit sample; x must be sign-extended to MAX_DATA.
    function automatic logic [IDX_W-1:0] lsc(input logic [MAX_DATA-1:0] x, input int data_w);
        logic [IDX_W-1:0] n;
        logic             run;
        n   = '0;
        run = 1'b1;
        for (int i = MAX_DATA - 2; i >= 0; i--) begin
            if (i <= data_w - 2) begin
                if (run && (x[i] == x[data_w-1])) begin
                    n = n + 1'b1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [IDX_W-1:0] min_idx(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/bfp_index_scheduler_if.sv
// rtl/bfp_index_scheduler_if.sv - sample stream, release handshake and status bundle
interface bfp_index_scheduler_if
    import fft_bfp_pkg::*;
#(
    parameter int DATA  = 16,
    parameter int ARRAY = 16
);
    logic                  clear;
    logic                  valid_in;
    logic [DATA*ARRAY-1:0] re_in;
    logic [DATA*ARRAY-1:0] im_in;
    logic                  rel_req;
    logic [IDX_W-1:0]      index_l;
    logic [IDX_W-1:0]      index_h;
    logic                  index_vld;
    logic                  q_empty;
    logic                  q_full;
    logic                  ovf_err;
    logic                  udf_err;

    modport master (
        output clear, valid_in, re_in, im_in, rel_req,
        input  index_l, index_h, index_vld, q_empty, q_full, ovf_err, udf_err
    );

    modport slave (
        input  clear, valid_in, re_in, im_in, rel_req,
        output index_l, index_h, index_vld, q_empty, q_full, ovf_err, udf_err
    );
endinterface

// File: rtl/bfp_index_fifo.sv
// rtl/bfp_index_fifo.sv - synchronous queue of headroom index pairs
module bfp_index_fifo
    import fft_bfp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      clear,
    input  logic      push,
    input  logic      pop,
    input  idx_pair_t din,
    output idx_pair_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    idx_pair_t     mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_nxt;
    logic [AW:0]   rd_nxt;
    logic          do_push;
    logic          do_pop;

    // A pop on a full queue frees the slot the simultaneous push needs.
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & (~full | do_pop) & ~clear;
    assign wr_nxt  = wr_ptr + (AW+1)'(do_push);
    assign rd_nxt  = rd_ptr + (AW+1)'(do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/bfp_index_scheduler.sv
// rtl/bfp_index_scheduler.sv - per-frame headroom measurement and frame-synchronous index release
module bfp_index_scheduler
    import fft_bfp_pkg::*;
#(
    parameter int DATA        = 16,
    parameter int ARRAY       = 16,
    parameter int FRAME_BEATS = 32,
    parameter int DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    bfp_index_scheduler_if.slave  bus
);
    localparam int CNT_W = $clog2(FRAME_BEATS);

    logic [CNT_W-1:0] beat_cnt;
    logic [IDX_W-1:0] acc_l;
    logic [IDX_W-1:0] acc_h;
    logic [IDX_W-1:0] beat_l;
    logic [IDX_W-1:0] beat_h;
    logic [IDX_W-1:0] nxt_l;
    logic [IDX_W-1:0] nxt_h;
    logic [IDX_W-1:0] index_l_q;
    logic [IDX_W-1:0] index_h_q;
    logic             index_vld_q;
    logic             ovf_q;
    logic             udf_q;
    logic             beat_ok;
    logic             first_beat;
    logic             last_beat;
    logic             push;
    logic             pop_req;
    logic             pop_ok;
    logic             q_empty;
    logic             q_full;
    idx_pair_t        push_pair;
    idx_pair_t        head_pair;

    always_comb begin
        logic [IDX_W-1:0] lane_min;
        beat_l   = IDX_W'(DATA - 1);
        beat_h   = IDX_W'(DATA - 1);
        lane_min = '0;
        for (int i = 0; i < ARRAY; i++) begin
            lane_min = min_idx(lsc(MAX_DATA'($signed(bus.re_in[i*DATA +: DATA])), DATA),
                               lsc(MAX_DATA'($signed(bus.im_in[i*DATA +: DATA])), DATA));
            if (i < ARRAY / 2) begin
                beat_l = min_idx(beat_l, lane_min);
            end else begin
                beat_h = min_idx(beat_h, lane_min);
            end
        end
    end

    assign first_beat  = (beat_cnt == '0);
    assign last_beat   = (beat_cnt == CNT_W'(FRAME_BEATS - 1));
    assign nxt_l       = first_beat ? beat_l : min_idx(acc_l, beat_l);
    assign nxt_h       = first_beat ? beat_h : min_idx(acc_h, beat_h);
    assign beat_ok     = bus.valid_in & ~bus.clear;
    assign push        = beat_ok & last_beat;
    assign pop_req     = bus.rel_req & ~bus.clear;
    assign pop_ok      = pop_req & ~q_empty;
    assign push_pair.l = nxt_l;
    assign push_pair.h = nxt_h;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt <= '0;
            acc_l    <= '0;
            acc_h    <= '0;
        end else if (bus.clear) begin
            beat_cnt <= '0;
            acc_l    <= '0;
            acc_h    <= '0;
        end else if (beat_ok) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            acc_l    <= nxt_l;
            acc_h    <= nxt_h;
        end
    end

    bfp_index_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clear (bus.clear),
        .push  (push),
        .pop   (pop_req),
        .din   (push_pair),
        .dout  (head_pair),
        .full  (q_full),
        .empty (q_empty)
    );

    // Output indices survive clear so the consumer keeps its last valid shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            index_l_q   <= '0;
            index_h_q   <= '0;
            index_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else if (bus.clear) begin
            index_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            index_vld_q <= pop_ok;
            if (pop_ok) begin
                index_l_q <= head_pair.l;
                index_h_q <= head_pair.h;
            end
            ovf_q <= ovf_q | (push & q_full & ~pop_ok);
            udf_q <= udf_q | (pop_req & q_empty);
        end
    end

    assign bus.index_l   = index_l_q;
    assign bus.index_h   = index_h_q;
    assign bus.index_vld = index_vld_q;
    assign bus.q_empty   = q_empty;
    assign bus.q_full    = q_full;
    assign bus.ovf_err   = ovf_q;
    assign bus.udf_err   = udf_q;

endmodule

// File: tb/tb_bfp_index_scheduler.sv
// tb/tb_bfp_index_scheduler.sv - directed and randomized bench with a behavioural headroom model
module tb_bfp_index_scheduler;
    localparam int DATA  = 16;
    localparam int ARRAY = 16;
    localparam int FB    = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rstn;

    bfp_index_scheduler_if #(.DATA(DATA), .ARRAY(ARRAY)) bus ();

    bfp_index_scheduler #(.DATA(DATA), .ARRAY(ARRAY), .FRAME_BEATS(FB), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] re_s [ARRAY];
    logic [15:0] im_s [ARRAY];

    int m_cnt, m_acc_l, m_acc_h, m_il, m_ih, m_vld, m_ovf, m_udf;
    int m_q_l[$];
    int m_q_h[$];

    // Headroom = sample width minus the fewest two's-complement bits that hold the value.
    function automatic int headroom(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        for (int b = 1; b <= DATA; b++) begin
            if (v >= -(1 << (b - 1)) && v < (1 << (b - 1))) return DATA - b;
        end
        return 0;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all();
        check("index_l",   32'(bus.index_l),   32'(m_il));
        check("index_h",   32'(bus.index_h),   32'(m_ih));
        check("index_vld", 32'(bus.index_vld), 32'(m_vld));
        check("q_empty",   32'(bus.q_empty),   32'(m_q_l.size() == 0));
        check("q_full",    32'(bus.q_full),    32'(m_q_l.size() == DEPTH));
        check("ovf_err",   32'(bus.ovf_err),   32'(m_ovf));
        check("udf_err",   32'(bus.udf_err),   32'(m_udf));
    endtask

    task automatic model_reset();
        m_cnt = 0; m_acc_l = 0; m_acc_h = 0; m_il = 0; m_ih = 0;
        m_vld = 0; m_ovf = 0; m_udf = 0;
        m_q_l.delete(); m_q_h.delete();
    endtask

    task automatic model_step(input logic v, input logic r, input logic c);
        int bl, bh;
        m_vld = 0;
        if (c) begin
            m_cnt = 0; m_ovf = 0; m_udf = 0;
            m_q_l.delete(); m_q_h.delete();
            return;
        end
        if (r) begin
            if (m_q_l.size() > 0) begin
                m_il = m_q_l.pop_front();
                m_ih = m_q_h.pop_front();
                m_vld = 1;
            end else begin
                m_udf = 1;
            end
        end
        if (v) begin
            bl = DATA - 1; bh = DATA - 1;
            for (int i = 0; i < ARRAY; i++) begin
                if (i < ARRAY / 2) bl = imin(bl, imin(headroom(re_s[i]), headroom(im_s[i])));
                else               bh = imin(bh, imin(headroom(re_s[i]), headroom(im_s[i])));
            end
            m_acc_l = (m_cnt == 0) ? bl : imin(m_acc_l, bl);
            m_acc_h = (m_cnt == 0) ? bh : imin(m_acc_h, bh);
            if (m_cnt == FB - 1) begin
                if (m_q_l.size() < DEPTH) begin
                    m_q_l.push_back(m_acc_l);
                    m_q_h.push_back(m_acc_h);
                end else begin
                    m_ovf = 1;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic tick(input logic v, input logic r, input logic c);
        bus.valid_in = v;
        bus.rel_req  = r;
        bus.clear    = c;
        for (int i = 0; i < ARRAY; i++) begin
            bus.re_in[i*DATA +: DATA] = re_s[i];
            bus.im_in[i*DATA +: DATA] = im_s[i];
        end
        model_step(v, r, c);
        @(posedge clk);
        #1;
        check_all();
        bus.valid_in = 1'b0;
        bus.rel_req  = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic fill_const(input logic [15:0] val);
        for (int i = 0; i < ARRAY; i++) begin
            re_s[i] = val;
            im_s[i] = val;
        end
    endtask

    task automatic fill_rand();
        logic signed [15:0] t;
        for (int i = 0; i < ARRAY; i++) begin
            t = 16'($urandom);
            re_s[i] = 16'(t >>> $urandom_range(0, 15));
            t = 16'($urandom);
            im_s[i] = 16'(t >>> $urandom_range(0, 15));
        end
    endtask

    task automatic rand_frame();
        for (int b = 0; b < FB; b++) begin
            fill_rand();
            tick(1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rstn = 1'b0;
        bus.clear = 1'b0; bus.valid_in = 1'b0; bus.rel_req = 1'b0;
        bus.re_in = '0; bus.im_in = '0;
        fill_const(16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rstn = 1'b1;

        // Single frame with one large sample on lane 3, then release.
        for (int b = 0; b < FB; b++) begin
            fill_const(16'h0100);
            if (b == 7) re_s[3] = 16'h4000;
            tick(1'b1, 1'b0, 1'b0);
        end
        check("frame1_l_exp", 32'(m_q_l[0]), 32'd0);
        check("frame1_h_exp", 32'(m_q_h[0]), 32'd6);
        tick(1'b0, 1'b1, 1'b0);

        // All-zero frame, then all 16'hFFF0 frame.
        fill_const(16'h0000);
        for (int b = 0; b < FB; b++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("zero_frame", 32'(bus.index_l), 32'd15);
        fill_const(16'hFFF0);
        for (int b = 0; b < FB; b++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("neg_frame", 32'(bus.index_h), 32'd11);

        // Gapped valid_in across two frames.
        for (int b = 0; b < 2 * FB; b++) begin
            fill_rand();
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        repeat (2) tick(1'b0, 1'b1, 1'b0);

        // Five frames without release: fifth is dropped, four pops in order.
        repeat (5) rand_frame();
        repeat (5) begin
            tick(1'b0, 1'b1, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end

        // Underflow, then same-cycle release on the last beat of a frame.
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        for (int b = 0; b < FB; b++) begin
            fill_rand();
            tick(1'b1, (b == FB - 1), 1'b0);
        end
        tick(1'b0, 1'b1, 1'b0);

        // Clear at beat 10 with a beat presented in the clear cycle.
        for (int b = 0; b < 10; b++) begin
            fill_const(16'h4000);
            tick(1'b1, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b1);
        for (int b = 0; b < FB; b++) begin
            fill_const(16'h0010);
            tick(1'b1, 1'b0, 1'b0);
        end
        tick(1'b0, 1'b1, 1'b0);
        check("post_clear_l", 32'(bus.index_l), 32'd10);

        // Asynchronous reset mid-frame.
        repeat (5) begin
            fill_rand();
            tick(1'b1, 1'b0, 1'b0);
        end
        rstn = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        rand_frame();
        tick(1'b0, 1'b1, 1'b0);

        // Randomized soak including held rel_req and occasional clear.
        for (int n = 0; n < 1200; n++) begin
            fill_rand();
            tick($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
